// File: rtl/ped_pkg.sv
// Shared types and timing constants for the pedestrian request path and the
// intersection traffic controller it feeds.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2,
    LOCKOUT = 2'd3
  } ped_state_e;

  localparam int PRESS_CNT_W = 8;

  // Button conditioner defaults
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_LOCKOUT_CYCLES  = 15;
  localparam int DEF_CNT_W           = 4;

  // Traffic controller phase timing, in clock cycles
  localparam int TC_MIN_GREEN_CYCLES = 20;
  localparam int TC_YELLOW_CYCLES    = 5;
  localparam int TC_ALL_RED_CYCLES   = 2;
  localparam int TC_WALK_CYCLES      = 10;

  // Statistics counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [PRESS_CNT_W-1:0] sat_inc(input logic [PRESS_CNT_W-1:0] v);
    return (v == '1) ? v : v + PRESS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises the raw push button, debounces it and emits a one-cycle pulse
// on each accepted press (rising edge of the debounced level).
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw_i,
  output logic press_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   db_q, db_d;
  logic                   db_prev_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw_i};
    end
  end

  // A new level is only accepted after it has disagreed with db for
  // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    db_d      = db_q;
    if (sync_out != db_q) begin
      if (deb_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync_out;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt_q <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  assign press_o = db_q & ~db_prev_q;

endmodule

// File: rtl/ped_request_conditioner.sv
// Latches a debounced pedestrian press as a level request to the traffic
// controller and enforces a lockout after each crossing.
module ped_request_conditioner
  import ped_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   button_raw,
  input  logic                   crossing_active,
  output logic                   pedestrian_button,
  output logic                   request_pending,
  output logic                   lockout,
  output logic [PRESS_CNT_W-1:0] press_count
);

  logic press;

  ped_state_e             state_q, state_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   queued_q, queued_d;
  logic                   ped_q, ped_d;
  logic                   pend_q, pend_d;
  logic                   lock_q, lock_d;
  logic [PRESS_CNT_W-1:0] cnt_q, cnt_d;

  button_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .button_raw_i (button_raw),
    .press_o      (press)
  );

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    queued_d   = queued_q;
    case (state_q)
      IDLE: begin
        if (press) state_d = PENDING;
      end
      PENDING: begin
        if (crossing_active) state_d = SERVING;
      end
      SERVING: begin
        if (!crossing_active) begin
          state_d    = LOCKOUT;
          lock_cnt_d = CNT_W'(LOCKOUT_CYCLES - 1);
          queued_d   = 1'b0;
        end
      end
      LOCKOUT: begin
        // A press on the final lockout cycle still counts as queued.
        if (lock_cnt_q == '0) begin
          state_d  = (queued_q || press) ? PENDING : IDLE;
          queued_d = 1'b0;
        end else begin
          lock_cnt_d = lock_cnt_q - CNT_W'(1);
          if (press) queued_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so the registered values line up with state_q.
  always_comb begin
    ped_d  = (state_d == PENDING);
    lock_d = (state_d == LOCKOUT);
    pend_d = (state_d == PENDING) || ((state_d == LOCKOUT) && queued_d);
    cnt_d  = press ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      queued_q   <= 1'b0;
      ped_q      <= 1'b0;
      pend_q     <= 1'b0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      queued_q   <= queued_d;
      ped_q      <= ped_d;
      pend_q     <= pend_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pedestrian_button = ped_q;
  assign request_pending   = pend_q;
  assign lockout           = lock_q;
  assign press_count       = cnt_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Self-checking bench for ped_request_conditioner: scripted segment table,
// randomized run against a behavioural model, saturation and async reset.
module tb_ped_request_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LOCK = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       button_raw;
  logic       crossing_active;
  logic       pedestrian_button;
  logic       request_pending;
  logic       lockout;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ped_request_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LOCKOUT_CYCLES  (LOCK),
    .CNT_W           (4)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .button_raw        (button_raw),
    .crossing_active   (crossing_active),
    .pedestrian_button (pedestrian_button),
    .request_pending   (request_pending),
    .lockout           (lockout),
    .press_count       (press_count)
  );

  // Behavioural model: raw input delayed SYNC edges, a level accepted after
  // DEB consecutive disagreeing samples, and a request/lockout state machine.
  int mHist [SYNC];
  int mAcc, mRun, mRose;
  int mState;   // 0 idle, 1 waiting for crossing, 2 crossing, 3 lockout
  int mLeft, mQueued, mCount;

  task automatic modelReset();
    for (int i = 0; i < SYNC; i++) mHist[i] = 0;
    mAcc = 0; mRun = 0; mRose = 0;
    mState = 0; mLeft = 0; mQueued = 0; mCount = 0;
  endtask

  task automatic modelStep(input logic raw, input logic ca);
    int syncLvl;
    int pressNow;
    int oldAcc;
    syncLvl  = mHist[SYNC-1];
    pressNow = mRose;
    oldAcc   = mAcc;
    case (mState)
      0: if (pressNow != 0) mState = 1;
      1: if (ca) mState = 2;
      2: if (!ca) begin mState = 3; mLeft = LOCK; mQueued = 0; end
      default: begin
        if (pressNow != 0) mQueued = 1;
        mLeft = mLeft - 1;
        if (mLeft == 0) begin
          mState  = (mQueued != 0) ? 1 : 0;
          mQueued = 0;
        end
      end
    endcase
    if (pressNow != 0 && mCount < 255) mCount = mCount + 1;
    if (syncLvl != mAcc) begin
      mRun = mRun + 1;
      if (mRun == DEB) begin mAcc = syncLvl; mRun = 0; end
    end else begin
      mRun = 0;
    end
    mRose = (mAcc == 1 && oldAcc == 0) ? 1 : 0;
    for (int i = SYNC - 1; i > 0; i--) mHist[i] = mHist[i-1];
    mHist[0] = raw ? 1 : 0;
  endtask

  task automatic applyStimulus(input logic raw, input logic ca, input int n);
    for (int c = 0; c < n; c++) begin
      button_raw      = raw;
      crossing_active = ca;
      @(posedge clk);
      modelStep(raw, ca);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic ePed, input logic ePend,
                             input logic eLock, input logic [7:0] eCnt);
    checks++;
    if ({pedestrian_button, request_pending, lockout, press_count} !== {ePed, ePend, eLock, eCnt}) begin
      errors++;
      $display("[TB] FAIL %s: got ped=%0b pend=%0b lock=%0b cnt=%0d, expected ped=%0b pend=%0b lock=%0b cnt=%0d",
               name, pedestrian_button, request_pending, lockout, press_count, ePed, ePend, eLock, eCnt);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n         = 1'b0;
    button_raw      = 1'b0;
    crossing_active = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       raw;
    logic       ca;
    int         n;
    logic       ePed;
    logic       ePend;
    logic       eLock;
    logic [7:0] eCnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int rawLeft;
    int caLeft;
    logic rRaw;
    logic rCa;

    // Segment table: hold inputs for n cycles, then compare the outputs.
    tbl.push_back('{1'b0, 1'b0, 50, 1'b0, 1'b0, 1'b0, 8'd0}); // 0 idle after reset
    tbl.push_back('{1'b1, 1'b0,  3, 1'b0, 1'b0, 1'b0, 8'd0}); // 1 short glitch
    tbl.push_back('{1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 8'd0}); // 2 glitch rejected
    tbl.push_back('{1'b1, 1'b0,  6, 1'b0, 1'b0, 1'b0, 8'd0}); // 3 one cycle before request
    tbl.push_back('{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 8'd1}); // 4 request at k+7
    tbl.push_back('{1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0, 8'd1}); // 5 level held
    tbl.push_back('{1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b0, 8'd1}); // 6 release ignored
    tbl.push_back('{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 8'd1}); // 7 crossing starts
    tbl.push_back('{1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b0, 8'd2}); // 8 press while serving
    tbl.push_back('{1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0, 8'd2}); // 9
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 8'd2}); // 10 lockout entered
    tbl.push_back('{1'b0, 1'b0, 13, 1'b0, 1'b0, 1'b1, 8'd2}); // 11
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 8'd2}); // 12 last lockout cycle
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 8'd2}); // 13 back to idle
    tbl.push_back('{1'b1, 1'b0,  7, 1'b1, 1'b1, 1'b0, 8'd3}); // 14 new request
    tbl.push_back('{1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0, 8'd3}); // 15 serving
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 8'd3}); // 16 lockout
    tbl.push_back('{1'b1, 1'b0,  7, 1'b0, 1'b1, 1'b1, 8'd4}); // 17 queued press
    tbl.push_back('{1'b1, 1'b0,  7, 1'b0, 1'b1, 1'b1, 8'd4}); // 18 still locked out
    tbl.push_back('{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 8'd4}); // 19 queued request issued
    tbl.push_back('{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 8'd4}); // 20 serving
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 8'd4}); // 21 lockout
    tbl.push_back('{1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b0, 8'd4}); // 22 expires to idle
    tbl.push_back('{1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b0, 8'd4}); // 23 crossing_active ignored in idle
    tbl.push_back('{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 8'd5}); // 24 press with crossing high
    tbl.push_back('{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 8'd5}); // 25 serving next cycle
    tbl.push_back('{1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0, 8'd5}); // 26
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 8'd5}); // 27 lockout
    tbl.push_back('{1'b0, 1'b0,  8, 1'b0, 1'b0, 1'b1, 8'd5}); // 28
    tbl.push_back('{1'b1, 1'b0,  6, 1'b0, 1'b0, 1'b1, 8'd5}); // 29
    tbl.push_back('{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 8'd6}); // 30 press on final lockout cycle

    // Reset held with the button bouncing: everything stays cleared.
    reset_n         = 1'b0;
    button_raw      = 1'b0;
    crossing_active = 1'b0;
    modelReset();
    for (int i = 0; i < 8; i++) begin
      button_raw = ~button_raw;
      @(posedge clk);
      #1;
      if (i % 2 == 1) checkOutput("reset_hold", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    @(negedge clk);
    button_raw = 1'b0;
    reset_n    = 1'b1;

    for (int v = 0; v < tbl.size(); v++) begin
      applyStimulus(tbl[v].raw, tbl[v].ca, tbl[v].n);
      checkOutput($sformatf("seg%0d", v), tbl[v].ePed, tbl[v].ePend, tbl[v].eLock, tbl[v].eCnt);
    end

    // Randomized run compared cycle by cycle against the model.
    doReset();
    rawLeft = 0;
    caLeft  = 0;
    rRaw    = 1'b0;
    rCa     = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (rawLeft == 0) begin rRaw = ~rRaw; rawLeft = $urandom_range(1, 8); end
      if (caLeft == 0)  begin rCa = ~rCa;   caLeft  = $urandom_range(1, 40); end
      rawLeft--;
      caLeft--;
      applyStimulus(rRaw, rCa, 1);
      checkOutput("random", mState == 1, (mState == 1) || (mState == 3 && mQueued != 0),
                  mState == 3, 8'(mCount));
    end

    // 300 clean presses: the counter must saturate, not wrap.
    doReset();
    for (int p = 0; p < 300; p++) begin
      applyStimulus(1'b1, 1'b0, 6);
      applyStimulus(1'b0, 1'b0, 6);
    end
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("saturate", 1'b1, 1'b1, 1'b0, 8'd255);

    // Reset asserted between edges must clear the request without a clock.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ped_request_conditioner.md
Name: ped_request_conditioner

Overview:
Front-end stage that drives the pedestrian_button input of the intersection traffic controller. It synchronises and debounces the raw kerb-side push button and latches one request. It holds that request as a level until the controller reports the crossing active. After the crossing ends, it enforces a lockout interval so back-to-back presses cannot starve vehicle traffic.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on button_raw (min 2)
DEBOUNCE_CYCLES, 4, consecutive cycles a new level must persist before it is accepted (min 1)
LOCKOUT_CYCLES, 15, cycles after crossing end during which no new request is issued (min 1)
CNT_W, 4, width of debounce/lockout counters; must hold max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES)

Ports:
clk  input  1  system clock; single clock domain
reset_n  input  1  asynchronous, active-low reset
button_raw  input  1  asynchronous push-button level, 1 = pressed
crossing_active  input  1  pedestrian_crossing output of traffic controller, 1 = crossing in progress
pedestrian_button  output  1  registered request level to traffic controller
request_pending  output  1  registered; 1 while a request is waiting or queued during lockout
lockout  output  1  registered; 1 in LOCKOUT state
press_count  output  8  registered, saturating count of accepted debounced presses

Behaviour:
- Reset: reset_n low asynchronously clears all flops.
  - Synchroniser, debounced level db, db_prev, counters, and the queued flag go to 0; state goes to IDLE.
  - All outputs go to 0. Release is synchronous to clk.
- Synchroniser: SYNC_STAGES flop chain; sync_out is the last stage.
- Debounce:
  - While sync_out == db, deb_cnt = 0.
  - While they differ, deb_cnt increments each cycle.
  - When deb_cnt == DEBOUNCE_CYCLES-1 and the levels still differ, db <= sync_out and deb_cnt <= 0.
  - Pulses shorter than DEBOUNCE_CYCLES produce no change.
- Press event: press = db & ~db_prev (one cycle). Release edges are ignored.
- press_count increments on every press in any state and saturates at 255 (no wrap).
- FSM states: IDLE, PENDING, SERVING, LOCKOUT.
  - IDLE: press -> PENDING. crossing_active is ignored.
  - PENDING: pedestrian_button = 1. crossing_active == 1 -> SERVING. Further presses are counted but have no other effect.
  - SERVING: pedestrian_button = 0. Presses are ignored except for the count. crossing_active == 0 -> LOCKOUT, with lock_cnt <= LOCKOUT_CYCLES-1 and queued <= 0.
  - LOCKOUT: lock_cnt decrements each cycle. A press sets queued. When lock_cnt == 0, go to PENDING if (queued | press), else IDLE; clear queued.
- Outputs are registered, decoded from the next state so they align with the state register:
  - pedestrian_button = (state == PENDING)
  - lockout = (state == LOCKOUT)
  - request_pending = PENDING | (LOCKOUT & queued)
- Latency: button_raw first sampled high at edge k and held. The first edge at which the synchroniser captures it is k+1. pedestrian_button rises after edge k + SYNC_STAGES + DEBOUNCE_CYCLES + 1 (= k+7 with defaults).
- Request level is held indefinitely in PENDING. The controller acts on it only in its red phase, so no timeout applies.
- Simultaneous events:
  - Press in IDLE with crossing_active already 1 -> PENDING this cycle, SERVING next cycle.
  - crossing_active falling in PENDING (without having been seen high) -> stay PENDING.
- Reset mid-operation drops any pending or queued request. press_count is lost.
- Counter widths are unsigned CNT_W. Compares are exact-equality. No arithmetic wrap is reachable.

Decomposition:
- Shared package (ped_pkg): state enum {IDLE, PENDING, SERVING, LOCKOUT} as a 2-bit typedef, PRESS_CNT_W = 8, and default timing constants. The traffic controller's timing constants migrate to this package as well.
- One sub-module, button_debounce: synchroniser, debounce counter, db level, and the press pulse output, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES.
- The top level holds the FSM, lockout counter, and statistics.

Test Plan:
- Reset then idle: hold reset_n=0 with button_raw toggling -> all outputs 0. After release with button_raw=0 for 50 cycles -> outputs remain 0 and press_count=0.
- Glitch rejection: button_raw high for 3 cycles (< DEBOUNCE_CYCLES=4) -> pedestrian_button stays 0 and press_count stays 0.
- Clean press: button_raw high from edge 10 for 20 cycles -> pedestrian_button=1 after edge 17 and press_count=1. Then crossing_active=1 at cycle 30 -> pedestrian_button=0 after edge 31.
- Lockout with queue: crossing_active falls at cycle 60, with a second debounced press at cycle 65 -> lockout=1 for 15 cycles and request_pending=1 from cycle 66. PENDING (pedestrian_button=1) after lockout expires, press_count=2.
- Lockout without queue: no press during lockout -> IDLE after 15 cycles with pedestrian_button=0. Presses during SERVING are counted but not queued.
- Saturation and async reset: 300 debounced presses -> press_count=255. Assert reset_n=0 mid-PENDING between clock edges -> pedestrian_button=0 immediately, without waiting for a clock edge.
